data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the CPU data-memory interface. Accepts one load/store request
//  per handshake, waits a programmable latency, commits the access, then returns
//  aligned, mode-extended load data with a one-cycle done strobe.
//  Sits between the CPU datapath and a word-organised on-chip RAM.
//  Replaces the zero-latency memory model so stall logic can be exercised.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words stored; word index = address[31:2]
//  LATENCY  2     cycles from request accept to done; legal range 1..15
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   synchronous, active-high
//  address    in   32  byte address, sampled on accept
//  writeData  in   32  store data, right-justified for byte/half, sampled on accept
//  memWrite   in   1   store request
//  memRead    in   1   load request
//  memMode    in   3   000 word, 001 half signed, 010 half unsigned,
//                      011 byte signed, 100 byte unsigned, 101-111 reserved
//  ready      out  1   responder idle; request accepted when ready && (memRead || memWrite)
//  readData   out  32  load result, valid only while done=1 for a load
//  done       out  1   one-cycle completion strobe, for loads and stores
//  error      out  1   qualifies done: access was illegal and had no effect
// BEHAVIOUR
//  - Reset values: ready=1, done=0, error=0, readData=0, FSM=IDLE.
//  - Reset also zeroes every RAM word, in the same cycle.
//  - FSM states IDLE, WAIT, RESP.
//  - IDLE: ready=1. On accept, latch address/data/mode/op, load cnt=LATENCY-1,
//    then go to WAIT, or to RESP if LATENCY==1.
//  - WAIT: ready=0. Decrement cnt; when cnt reaches 0, go to RESP.
//  - RESP: commit the store or read the RAM; assert done (plus readData/error)
//    for exactly this cycle; set ready=1 and return to IDLE.
//  - Latency: done is asserted LATENCY cycles after the accept edge.
//  - Next accept: earliest is the cycle after done, i.e. no back-to-back overlap.
//  - Stores: word writes all 4 bytes.
//    - half writes bytes [a1*2 +: 2] from writeData[15:0].
//    - byte writes byte a[1:0] from writeData[7:0].
//    - Little-endian byte lanes; other bytes unchanged.
//  - Loads: select the lane from a[1:0], then sign- or zero-extend to 32 bits per memMode.
//  - Requests while ready=0 are ignored; the initiator must hold them.
//  - memRead && memWrite together: treated as a store; done asserted with error=1.
//  - Out of range (address[31:2] >= DEPTH):
//    - stores are dropped; loads return 0; error=1.
//  - Reserved memMode: no RAM effect; readData=0; error=1.
//  - Reset asserted in WAIT/RESP: the pending store is not committed; no done is issued.
//  - error and readData are 0 whenever done=0.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN
//    defined: misaligned access (half with a[0]=1; word with a[1:0]!=0)
//      -> no RAM effect; readData=0; done with error=1.
//    undefined: low address bits are forced to alignment (a[0]=0 for half,
//      a[1:0]=0 for word) and the access completes normally with error=0.
// TESTING
//  1. Reset, store word 0xDEADBEEF @0x10, then load word @0x10
//     -> done 2 cycles after each accept; readData=0xDEADBEEF; error=0.
//  2. Store byte 0x80 @0x13; load byte signed @0x13 -> 0xFFFFFF80.
//     Load byte unsigned -> 0x00000080. Load word @0x10 -> 0x80ADBEEF.
//  3. Load half @0x12 signed after test 2 -> 0xFFFF80AD.
//     Load half @0x11: with MISALIGN_TRAP_EN -> error=1, readData=0;
//     without -> same as @0x10, i.e. 0xFFFFBEEF.
//  4. Store to address DEPTH*4 -> done, error=1; word 0 unchanged.
//     memRead && memWrite together -> error=1; reserved memMode 3'b111 -> error=1.
//  5. Store word 0x12345678 @0x20; assert reset in WAIT; release reset
//     -> no done; load @0x20 returns 0; ready=1 the cycle after reset.
//  6. Hold memRead high continuously with LATENCY=1
//     -> done every 2nd cycle; ready toggles 1,0; no lost or duplicate responses.

Source files
------------

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port: one request per handshake, programmable
// latency, aligned/extended load data. Optional build macro: DMEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
    parameter int DEPTH   = 1024,   // words; must be a power of two >= 2
    parameter int LATENCY = 2       // accept-to-done cycles, 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [2:0]  memMode,
    output logic        ready,
    output logic [31:0] readData,
    output logic        done,
    output logic        error
);

    localparam int          IW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  mode_q;
    logic        wr_q;
    logic        rd_q;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          in_resp;
    logic          both;
    logic          mode_ok;
    logic          in_range;
    logic          misalign_err;
    logic          acc_err;
    logic          commit;
    logic          is_word;
    logic          is_half;
    logic [1:0]    lane;
    logic [IW-1:0] idx;
    logic [31:0]   rword;
    logic [31:0]   wmerge;
    logic [15:0]   hw;
    logic [7:0]    by;
    logic [31:0]   ld;

    assign accept = (state == IDLE) && (memRead || memWrite);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (accept) begin
                cnt_nxt   = 4'(LATENCY - 1);
                state_nxt = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access decode on the latched request
    assign both     = wr_q && rd_q;
    assign mode_ok  = (mode_q <= 3'b100);
    assign in_range = (addr_q[31:2] < DEPTH_W);
    assign is_word  = (mode_q == 3'b000);
    assign is_half  = (mode_q == 3'b001) || (mode_q == 3'b010);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_err = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
`else
    assign misalign_err = 1'b0;
`endif

    // Lane with low bits forced to alignment; identical to addr when trapping is on
    always_comb begin
        lane = addr_q[1:0];
        if (is_word)      lane = 2'b00;
        else if (is_half) lane = {addr_q[1], 1'b0};
    end

    assign acc_err = both || !mode_ok || !in_range || misalign_err;
    assign idx     = addr_q[IW+1:2];
    assign rword   = mem[idx];
    assign commit  = (state == RESP) && wr_q && !acc_err;

    always_comb begin
        wmerge = rword;
        if (is_word)      wmerge = wdata_q;
        else if (is_half) wmerge[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
        else              wmerge[{lane, 3'b000} +: 8]     = wdata_q[7:0];
    end

    assign hw = lane[1] ? rword[31:16] : rword[15:0];
    assign by = rword[{lane, 3'b000} +: 8];

    always_comb begin
        case (mode_q)
            3'b000:  ld = rword;
            3'b001:  ld = {{16{hw[15]}}, hw};
            3'b010:  ld = {16'h0000, hw};
            3'b011:  ld = {{24{by[7]}}, by};
            3'b100:  ld = {24'h000000, by};
            default: ld = 32'h0;
        endcase
    end

    // A reset landing in RESP swallows the completion as well as the commit
    assign in_resp  = (state == RESP) && !reset;
    assign ready    = (state == IDLE);
    assign done     = in_resp;
    assign error    = in_resp && acc_err;
    assign readData = (in_resp && rd_q && !wr_q && !acc_err) ? ld : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mode_q  <= 3'b000;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q  <= address;
                wdata_q <= writeData;
                mode_q  <= memMode;
                wr_q    <= memWrite;
                rd_q    <= memRead;
            end
            if (commit) mem[idx] <= wmerge;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for the main sequence,
// LATENCY=1 instance for the held-request throughput check.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0, writeData = '0;
    logic        memWrite = 1'b0, memRead = 1'b0;
    logic [2:0]  memMode = 3'b000;
    logic        ready, done, error;
    logic [31:0] readData;

    logic [31:0] address1 = '0, writeData1 = '0;
    logic        memWrite1 = 1'b0, memRead1 = 1'b0;
    logic [2:0]  memMode1 = 3'b000;
    logic        ready1, done1, error1;
    logic [31:0] readData1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .address(address), .writeData(writeData),
        .memWrite(memWrite), .memRead(memRead), .memMode(memMode),
        .ready(ready), .readData(readData), .done(done), .error(error));

    data_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .address(address1), .writeData(writeData1),
        .memWrite(memWrite1), .memRead(memRead1), .memMode(memMode1),
        .ready(ready1), .readData(readData1), .done(done1), .error(error1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance; lat counts negedges after accept until done
    task automatic xact(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic wr, input logic rd, input logic [2:0] m,
                        output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        address = a; writeData = wd; memWrite = wr; memRead = rd; memMode = m;
        @(posedge clk);
        rdata = '0; err = 1'b0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            memWrite = 1'b0; memRead = 1'b0;
            if (done) begin
                rdata = readData;
                err   = error;
                break;
            end
        end
    endtask

    task automatic check_x(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic wr, input logic rd, input logic [2:0] m,
                           input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        xact(tag, a, wd, wr, rd, m, rdata, err, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_data"}, rdata, exp_data);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        int dones;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_rdata", readData, 32'h0);
        reset = 1'b0;

        // Word store/load
        check_x("st_word", 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
        check_x("ld_word", 32'h10, 32'h0, 1'b0, 1'b1, 3'b000, 32'hDEADBEEF, 1'b0);

        // Byte store, signed/unsigned byte loads
        check_x("st_byte", 32'h13, 32'h00000080, 1'b1, 1'b0, 3'b011, 32'h0, 1'b0);
        check_x("ld_bs", 32'h13, 32'h0, 1'b0, 1'b1, 3'b011, 32'hFFFFFF80, 1'b0);
        check_x("ld_bu", 32'h13, 32'h0, 1'b0, 1'b1, 3'b100, 32'h00000080, 1'b0);
        check_x("ld_w2", 32'h10, 32'h0, 1'b0, 1'b1, 3'b000, 32'h80ADBEEF, 1'b0);

        // Half loads, including the misaligned case
        check_x("ld_hs12", 32'h12, 32'h0, 1'b0, 1'b1, 3'b001, 32'hFFFF80AD, 1'b0);
        check_x("ld_hu12", 32'h12, 32'h0, 1'b0, 1'b1, 3'b010, 32'h000080AD, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check_x("ld_hs11", 32'h11, 32'h0, 1'b0, 1'b1, 3'b001, 32'h0, 1'b1);
`else
        check_x("ld_hs11", 32'h11, 32'h0, 1'b0, 1'b1, 3'b001, 32'hFFFFBEEF, 1'b0);
`endif

        // Half store into upper lane leaves lower lane alone
        check_x("st_half", 32'h16, 32'hAAAA1234, 1'b1, 1'b0, 3'b010, 32'h0, 1'b0);
        check_x("ld_w14", 32'h14, 32'h0, 1'b0, 1'b1, 3'b000, 32'h12340000, 1'b0);

        // Illegal accesses
        check_x("st_oor", 32'h1000, 32'hFFFFFFFF, 1'b1, 1'b0, 3'b000, 32'h0, 1'b1);
        check_x("ld_w0", 32'h0, 32'h0, 1'b0, 1'b1, 3'b000, 32'h0, 1'b0);
        check_x("ld_oor", 32'h1000, 32'h0, 1'b0, 1'b1, 3'b000, 32'h0, 1'b1);
        check_x("rw_both", 32'h10, 32'h0, 1'b1, 1'b1, 3'b000, 32'h0, 1'b1);
        check_x("ld_w3", 32'h10, 32'h0, 1'b0, 1'b1, 3'b000, 32'h80ADBEEF, 1'b0);
        check_x("ld_rsv", 32'h10, 32'h0, 1'b0, 1'b1, 3'b111, 32'h0, 1'b1);
        check_x("st_rsv", 32'h10, 32'h11111111, 1'b1, 1'b0, 3'b101, 32'h0, 1'b1);
        check_x("ld_w4", 32'h10, 32'h0, 1'b0, 1'b1, 3'b000, 32'h80ADBEEF, 1'b0);

        // Reset while a store is waiting
        @(negedge clk);
        address = 32'h20; writeData = 32'h12345678; memWrite = 1'b1; memMode = 3'b000;
        @(posedge clk);
        @(negedge clk);
        memWrite = 1'b0;
        reset = 1'b1;
        chk("rstw_ready", 32'(ready), 32'd0);
        chk("rstw_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("rstw_ready1", 32'(ready), 32'd1);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rstw_nodone", 32'(dones), 32'd0);
        check_x("ld_w20", 32'h20, 32'h0, 1'b0, 1'b1, 3'b000, 32'h0, 1'b0);

        // LATENCY=1 instance: one store, then a held read
        @(negedge clk);
        address1 = 32'h0; writeData1 = 32'hCAFE0001; memWrite1 = 1'b1; memMode1 = 3'b000;
        @(negedge clk);
        chk("l1_st_done", 32'(done1), 32'd1);
        chk("l1_st_err", 32'(error1), 32'd0);
        memWrite1 = 1'b0; memRead1 = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("l1_ready%0d", k), 32'(ready1), 32'((k % 2) == 0));
            chk($sformatf("l1_done%0d", k), 32'(done1), 32'((k % 2) == 1));
            chk($sformatf("l1_rdata%0d", k), readData1, ((k % 2) == 1) ? 32'hCAFE0001 : 32'h0);
            if (done1) dones++;
        end
        memRead1 = 1'b0;
        chk("l1_dones", 32'(dones), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
